vga_text_reader: RTL



---
 rtl/vga_text_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_text_reader.sv
// 80x30 text-mode VGA reader: 640x480@60 timing, RAM port-B word fetch, font lookup and
// attribute colouring. Pixel and sync outputs trail the counters by three cycles.
module vga_text_reader #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned TEXT_COLS = 80
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] addrb,
    input  logic [31:0] rdb,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank
);

    localparam int unsigned WordsPerRow = TEXT_COLS / 2;
    localparam logic [9:0] HVis       = 10'(H_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] HLast      = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VVis       = 10'(V_VISIBLE);
    localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] VLast      = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    // Stage 1: RAM data valid
    logic [3:0]  s1_vline_q, s1_vline_d;
    logic [2:0]  s1_px_q, s1_px_d;
    logic        s1_lane_q, s1_lane_d, s1_vis_q, s1_vis_d;
    logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_vb_q, s1_vb_d;
    // Stage 2: font data valid
    logic [6:0]  s2_attr_q, s2_attr_d;
    logic [2:0]  s2_px_q, s2_px_d;
    logic        s2_vis_q, s2_vis_d;
    logic        s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_vb_q, s2_vb_d;
    // Output registers
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;

    logic [7:0]  char_code, attr;
    logic [3:0]  fg_lvl;
    logic [11:0] fg, bg;
    logic        pix;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == HLast) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
        end

        // col = h[9:3], so the word index col[6:1] is h[9:4] and the lane is h[3]
        addrb = 11'(int'(vcnt_q[8:4]) * int'(WordsPerRow) + int'(hcnt_q[9:4]));

        s1_vline_d = vcnt_q[3:0];
        s1_px_d    = hcnt_q[2:0];
        s1_lane_d  = hcnt_q[3];
        s1_vis_d   = (hcnt_q < HVis) && (vcnt_q < VVis);
        s1_hs_d    = !((hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd));
        s1_vs_d    = !((vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd));
        s1_vb_d    = (vcnt_q >= VVis);

        char_code = s1_lane_q ? rdb[15:8] : rdb[31:24];
        attr      = s1_lane_q ? rdb[7:0]  : rdb[23:16];
        font_addr = {char_code, s1_vline_q};

        s2_attr_d = attr[6:0];
        s2_px_d   = s1_px_q;
        s2_vis_d  = s1_vis_q;
        s2_hs_d   = s1_hs_q;
        s2_vs_d   = s1_vs_q;
        s2_vb_d   = s1_vb_q;

        pix    = font_data[3'd7 - s2_px_q];
        fg_lvl = s2_attr_q[3] ? 4'hF : 4'hA;
        fg     = {s2_attr_q[2] ? fg_lvl : 4'h0,
                  s2_attr_q[1] ? fg_lvl : 4'h0,
                  s2_attr_q[0] ? fg_lvl : 4'h0};
        bg     = {s2_attr_q[6] ? 4'h8 : 4'h0,
                  s2_attr_q[5] ? 4'h8 : 4'h0,
                  s2_attr_q[4] ? 4'h8 : 4'h0};
        rgb_d    = s2_vis_q ? (pix ? fg : bg) : 12'h000;
        hsync_d  = s2_hs_q;
        vsync_d  = s2_vs_q;
        vblank_d = s2_vb_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            s1_vline_q <= '0;
            s1_px_q    <= '0;
            s1_lane_q  <= 1'b0;
            s1_vis_q   <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            s1_vb_q    <= 1'b0;
            s2_attr_q  <= '0;
            s2_px_q    <= '0;
            s2_vis_q   <= 1'b0;
            s2_hs_q    <= 1'b1;
            s2_vs_q    <= 1'b1;
            s2_vb_q    <= 1'b0;
            rgb_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            vblank_q   <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            s1_vline_q <= s1_vline_d;
            s1_px_q    <= s1_px_d;
            s1_lane_q  <= s1_lane_d;
            s1_vis_q   <= s1_vis_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_vb_q    <= s1_vb_d;
            s2_attr_q  <= s2_attr_d;
            s2_px_q    <= s2_px_d;
            s2_vis_q   <= s2_vis_d;
            s2_hs_q    <= s2_hs_d;
            s2_vs_q    <= s2_vs_d;
            s2_vb_q    <= s2_vb_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            vblank_q   <= vblank_d;
        end
    end

    assign red    = rgb_q[11:8];
    assign green  = rgb_q[7:4];
    assign blue   = rgb_q[3:0];
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign vblank = vblank_q;

endmodule
